// File: rtl/demod_lpf_scheduler.sv
// demod_lpf_scheduler
//   Time-shares one signed multiply-accumulate unit across NUM_CH low-pass FIR
//   channels of NUM_TAPS taps each. It sits behind the QPD demodulator, where
//   the x/y/sum x sin/cos products arrive as one packed vector per tick. All
//   filtered outputs are published together with a single valid pulse.
//   Coefficients are read from a shared external synchronous ROM.
//
//   State      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for tick_i; the accept cycle captures sample_i
//   S_LOAD     | write the captured samples into every delay line at wp
//   S_MAC      | issue taps k=0..NUM_TAPS-1 for channel ch (ROM + sample fetch)
//   S_DRAIN    | two cycles to let the product/accumulate stages empty
//   S_STORE    | saturate the accumulator into the shadow slot of channel ch
//   S_DONE     | results already published; advance wp, back to idle
//
// Ports
//   clk_i         clock
//   reset_ni      asynchronous active-low reset
//   tick_i        new-sample strobe, one cycle
//   sample_i      packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   coeff_addr_o  coefficient ROM address (0 outside S_MAC)
//   coeff_data_i  signed coefficient, valid one cycle after its address
//   result_o      packed signed filtered outputs, same packing as sample_i
//   valid_o       one-cycle pulse: result_o updated
//   busy_o        computation in progress
//   overrun_o     one-cycle pulse: a tick_i was dropped
module demod_lpf_scheduler #(
    parameter int NUM_CH    = 6,
    parameter int NUM_TAPS  = 41,
    parameter int DATA_W    = 32,
    parameter int COEFF_W   = 32,
    parameter int ACC_W     = 72,
    parameter int OUT_SHIFT = 32,
    localparam int AW       = $clog2(NUM_TAPS),
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       tick_i,
    input  logic [NUM_CH*DATA_W-1:0]   sample_i,
    output logic [AW-1:0]              coeff_addr_o,
    input  logic [COEFF_W-1:0]         coeff_data_i,
    output logic [NUM_CH*DATA_W-1:0]   result_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam int PW = DATA_W + COEFF_W;

    // Saturation bounds of a signed DATA_W value, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_DRAIN,
        S_STORE,
        S_DONE
    } state_t;

    state_t                      state_q;
    logic [CHW-1:0]              ch_q;
    logic [AW-1:0]               addr_q;
    logic [AW-1:0]               wp_q;
    logic                        drain_q;
    logic [NUM_CH*DATA_W-1:0]    samp_cap_q;
    logic [NUM_CH*DATA_W-1:0]    shadow_q;
    logic [NUM_CH*DATA_W-1:0]    result_q;
    logic                        valid_q;
    logic                        busy_q;
    logic                        ovr_q;

    logic signed [DATA_W-1:0]    dline_q [NUM_CH][NUM_TAPS];

    logic signed [DATA_W-1:0]    samp_s1_q;
    logic                        v1_q;
    logic                        v2_q;
    logic signed [PW-1:0]        prod_q;
    logic signed [ACC_W-1:0]     acc_q;

    logic [AW-1:0]               rd_idx_d;
    logic signed [DATA_W-1:0]    samp_rd_d;
    logic signed [PW-1:0]        prod_d;
    logic signed [ACC_W-1:0]     shifted_d;
    logic signed [DATA_W-1:0]    sat_d;
    logic [NUM_CH*DATA_W-1:0]    shadow_d;

    // Tap k lives at (wp - k) mod NUM_TAPS. When wp < k the sum wraps in AW
    // bits, but the true result lies in 0..NUM_TAPS-1 so the wrap is harmless.
    always_comb begin
        rd_idx_d = '0;
        if (wp_q >= addr_q) begin
            rd_idx_d = wp_q - addr_q;
        end else begin
            rd_idx_d = wp_q + AW'(NUM_TAPS) - addr_q;
        end
    end

    assign samp_rd_d = dline_q[ch_q][rd_idx_d];
    assign prod_d    = PW'($signed(coeff_data_i)) * PW'(samp_s1_q);
    assign shifted_d = acc_q >>> OUT_SHIFT;

    always_comb begin
        sat_d = shifted_d[DATA_W-1:0];
        if (shifted_d > SAT_MAX) begin
            sat_d = SAT_MAX[DATA_W-1:0];
        end else if (shifted_d < SAT_MIN) begin
            sat_d = SAT_MIN[DATA_W-1:0];
        end
    end

    // Shadow with the current channel's slot replaced. The last channel's
    // STORE publishes this directly, so all channels appear atomically.
    always_comb begin
        shadow_d = shadow_q;
        shadow_d[int'(ch_q)*DATA_W +: DATA_W] = sat_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            addr_q     <= '0;
            wp_q       <= '0;
            drain_q    <= 1'b0;
            samp_cap_q <= '0;
            shadow_q   <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ovr_q   <= tick_i && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (tick_i) begin
                        samp_cap_q <= sample_i;
                        busy_q     <= 1'b1;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ch_q    <= '0;
                    addr_q  <= '0;
                    state_q <= S_MAC;
                end
                S_MAC: begin
                    if (addr_q == AW'(NUM_TAPS-1)) begin
                        addr_q  <= '0;
                        drain_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q) begin
                        state_q <= S_STORE;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                S_STORE: begin
                    shadow_q <= shadow_d;
                    if (ch_q == CHW'(NUM_CH-1)) begin
                        result_q <= shadow_d;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        addr_q  <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_DONE: begin
                    wp_q    <= (wp_q == AW'(NUM_TAPS-1)) ? '0 : wp_q + 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    dline_q[c][t] <= '0;
                end
            end
        end else if (state_q == S_LOAD) begin
            for (int c = 0; c < NUM_CH; c++) begin
                dline_q[c][wp_q] <= samp_cap_q[c*DATA_W +: DATA_W];
            end
        end
    end

    // Three-stage MAC: fetch (ROM address + sample), registered product,
    // accumulate. The clear on k=0 issue never collides with an accumulate
    // because the previous channel's pipeline is empty by then.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            samp_s1_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            prod_q    <= '0;
            acc_q     <= '0;
        end else begin
            samp_s1_q <= samp_rd_d;
            v1_q      <= (state_q == S_MAC);
            v2_q      <= v1_q;
            if (v1_q) begin
                prod_q <= prod_d;
            end
            if (state_q == S_MAC && addr_q == '0) begin
                acc_q <= '0;
            end else if (v2_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end
        end
    end

    assign coeff_addr_o = addr_q;
    assign result_o     = result_q;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_demod_lpf_scheduler.sv
// tb_demod_lpf_scheduler
//   Directed bench for demod_lpf_scheduler with OUT_SHIFT=0 and a ROM model
//   holding coeff[k]=k+1 (or all 2^31-1 for the saturation vectors).
module tb_demod_lpf_scheduler;

    localparam int NCH = 6;
    localparam int NT  = 41;
    localparam int DW  = 32;
    localparam int CW  = 32;
    localparam int AW  = $clog2(NT);

    logic                 clk_i = 1'b0;
    logic                 reset_ni = 1'b0;
    logic                 tick_i = 1'b0;
    logic [NCH*DW-1:0]    sample_i = '0;
    logic [AW-1:0]        coeff_addr_o;
    logic [CW-1:0]        coeff_data_i = '0;
    logic [NCH*DW-1:0]    result_o;
    logic                 valid_o;
    logic                 busy_o;
    logic                 overrun_o;

    int checks   = 0;
    int failures = 0;
    int rom_mode = 0;
    int last_lat = 0;

    demod_lpf_scheduler #(
        .NUM_CH   (NCH),
        .NUM_TAPS (NT),
        .DATA_W   (DW),
        .COEFF_W  (CW),
        .ACC_W    (72),
        .OUT_SHIFT(0)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .tick_i      (tick_i),
        .sample_i    (sample_i),
        .coeff_addr_o(coeff_addr_o),
        .coeff_data_i(coeff_data_i),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rom_mode == 1) coeff_data_i <= 32'h7fff_ffff;
        else               coeff_data_i <= 32'(coeff_addr_o) + 32'd1;
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint res_ch(input int c);
        logic signed [DW-1:0] v;
        v = result_o[c*DW +: DW];
        return longint'(v);
    endfunction

    function automatic int exp_addr(input int c);
        for (int j = 0; j < NCH; j++) begin
            if (c >= 2 + 44*j && c < 2 + 44*j + NT) return c - (2 + 44*j);
        end
        return 0;
    endfunction

    function automatic logic [NCH*DW-1:0] all_ch(input logic [DW-1:0] v);
        logic [NCH*DW-1:0] s;
        for (int c = 0; c < NCH; c++) s[c*DW +: DW] = v;
        return s;
    endfunction

    // Accept one tick, then wait (bounded) for valid_o; returns in the valid cycle.
    task automatic run_tick(input logic [NCH*DW-1:0] s);
        int n;
        @(posedge clk_i); #1;
        tick_i   = 1'b1;
        sample_i = s;
        @(posedge clk_i); #1;
        tick_i   = 1'b0;
        sample_i = all_ch(32'h5a5a_5a5a);
        n = 1;
        while (valid_o !== 1'b1 && n < 400) begin
            @(posedge clk_i); #1;
            n++;
        end
        last_lat = n;
        if (valid_o !== 1'b1) check_val("valid_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk_i); #1;
        reset_ni = 1'b0;
        #2;
        reset_ni = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NCH*DW-1:0] s;
        longint orv;
        longint sum;
        int busy_err, valid_err, addr_err, valid_cyc, ov_err, valid_cnt;
        longint ov_res;

        // Reset state
        #12;
        check_val("rst_result", longint'(result_o != '0), 0);
        check_val("rst_valid", longint'(valid_o), 0);
        check_val("rst_busy", longint'(busy_o), 0);
        check_val("rst_addr", longint'(coeff_addr_o), 0);
        check_val("rst_overrun", longint'(overrun_o), 0);
        #1;
        reset_ni = 1'b1;

        // Latency, busy window and address sweep for one tick
        @(posedge clk_i); #1;
        tick_i   = 1'b1;
        sample_i = '0;
        check_val("busy_accept", longint'(busy_o), 0);
        @(posedge clk_i); #1;
        tick_i = 1'b0;
        busy_err = 0; valid_err = 0; addr_err = 0; valid_cyc = -1;
        for (int c = 1; c <= 268; c++) begin
            if (busy_o !== (c <= 266)) busy_err++;
            if (valid_o !== (c == 266)) valid_err++;
            if (valid_o === 1'b1 && valid_cyc < 0) valid_cyc = c;
            if (int'(coeff_addr_o) != exp_addr(c)) addr_err++;
            @(posedge clk_i); #1;
        end
        check_val("latency", valid_cyc, 266);
        check_val("busy_window", busy_err, 0);
        check_val("valid_pulse", valid_err, 0);
        check_val("addr_sweep", addr_err, 0);

        // Impulse on channel 0
        for (int n = 0; n <= NT; n++) begin
            s = '0;
            if (n == 0) s[DW-1:0] = 32'd1;
            run_tick(s);
            check_val($sformatf("imp_ch0_%0d", n), res_ch(0), (n < NT) ? longint'(n + 1) : 0);
            orv = 0;
            for (int c = 1; c < NCH; c++) orv |= res_ch(c);
            check_val($sformatf("imp_others_%0d", n), orv, 0);
        end

        // DC input of 100 on all channels
        sum = 0;
        for (int n = 0; n <= NT; n++) begin
            run_tick(all_ch(32'd100));
            if (n < NT) sum += n + 1;
            check_val($sformatf("dc_ch0_%0d", n), res_ch(0), 100 * sum);
            check_val($sformatf("dc_ch5_%0d", n), res_ch(5), 100 * sum);
        end
        check_val("dc_steady", res_ch(3), 86100);

        // Reset in the middle of a computation
        @(posedge clk_i); #1;
        tick_i   = 1'b1;
        sample_i = all_ch(32'd3);
        @(posedge clk_i); #1;
        tick_i = 1'b0;
        repeat (49) begin
            @(posedge clk_i); #1;
        end
        check_val("midrst_busy_before", longint'(busy_o), 1);
        reset_ni = 1'b0;
        #1;
        check_val("midrst_result", longint'(result_o != '0), 0);
        check_val("midrst_valid", longint'(valid_o), 0);
        check_val("midrst_busy", longint'(busy_o), 0);
        check_val("midrst_addr", longint'(coeff_addr_o), 0);
        #2;
        reset_ni = 1'b1;
        valid_cnt = 0;
        repeat (300) begin
            @(posedge clk_i); #1;
            if (valid_o === 1'b1) valid_cnt++;
        end
        check_val("midrst_no_valid", valid_cnt, 0);
        for (int n = 0; n < 3; n++) begin
            s = '0;
            if (n == 0) s[DW-1:0] = 32'd1;
            run_tick(s);
            check_val($sformatf("postrst_imp_ch0_%0d", n), res_ch(0), n + 1);
        end

        // Overrun: dropped ticks mid-computation and in the DONE cycle
        pulse_reset();
        @(posedge clk_i); #1;
        s = '0;
        s[DW-1:0] = 32'd1;
        tick_i   = 1'b1;
        sample_i = s;
        @(posedge clk_i); #1;
        tick_i = 1'b0;
        ov_err = 0; valid_cnt = 0; ov_res = -1;
        for (int c = 1; c <= 300; c++) begin
            if (overrun_o !== (c == 101 || c == 267)) ov_err++;
            if (valid_o === 1'b1) begin
                valid_cnt++;
                ov_res = res_ch(0);
            end
            if (c == 100 || c == 266) begin
                tick_i   = 1'b1;
                sample_i = all_ch(32'd7);
            end else begin
                tick_i   = 1'b0;
            end
            @(posedge clk_i); #1;
        end
        tick_i = 1'b0;
        check_val("ovr_pulses", ov_err, 0);
        check_val("ovr_valid_count", valid_cnt, 1);
        check_val("ovr_result", ov_res, 1);
        run_tick('0);
        check_val("ovr_wp_once", res_ch(0), 2);
        check_val("ovr_ch1", res_ch(1), 0);

        // Saturation, positive and negative
        pulse_reset();
        rom_mode = 1;
        s = '0;
        s[0*DW +: DW] = 32'h7fff_ffff;
        s[1*DW +: DW] = 32'h8000_0000;
        run_tick(s);
        check_val("sat_pos", res_ch(0), 64'sd2147483647);
        check_val("sat_neg", res_ch(1), -64'sd2147483648);
        check_val("sat_zero", res_ch(2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demod_lpf_scheduler.md
Name: demod_lpf_scheduler

Overview:
- Time-shares one signed multiply-accumulate unit across NUM_CH demodulator low-pass channels, each a NUM_TAPS-tap FIR.
- Replaces six parallel FIR instances behind the QPD demodulator: products (x/y/sum × sin/cos) enter as one packed vector per tick, filtered outputs leave with a single valid pulse.
- Coefficients come from a shared external synchronous ROM.

Parameters:
NUM_CH, 6, number of channels sharing the MAC
NUM_TAPS, 41, taps per channel (≥2)
DATA_W, 32, signed sample and result width
COEFF_W, 32, signed coefficient width
ACC_W, 72, signed accumulator width (≥ DATA_W+COEFF_W+clog2(NUM_TAPS))
OUT_SHIFT, 32, arithmetic right shift applied to accumulator before saturation

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
tick_i  in  1  new-sample strobe, one cycle
sample_i  in  NUM_CH*DATA_W  packed signed samples, channel c at [c*DATA_W +: DATA_W]
coeff_addr_o  out  clog2(NUM_TAPS)  coefficient ROM address
coeff_data_i  in  COEFF_W  signed coefficient, valid one cycle after address
result_o  out  NUM_CH*DATA_W  packed signed filtered outputs, same packing
valid_o  out  1  one-cycle pulse: result_o updated
busy_o  out  1  computation in progress
overrun_o  out  1  one-cycle pulse: tick_i dropped

Behaviour:
- Reset (async assert, sync release): all outputs 0; delay lines 0; write pointer wp=0; FSM IDLE. Assertion mid-computation aborts immediately; no valid_o follows.
- Delay line: per-channel circular buffer of NUM_TAPS samples. Tap k (k=0 newest) read at (wp−k) mod NUM_TAPS.
- Filter: y_c = Σ_{k=0}^{NUM_TAPS−1} coeff[k]·x_c[n−k]. Full-precision product, sign-extended into ACC_W accumulator; no intermediate truncation.
- Output: acc >>> OUT_SHIFT, saturated to signed DATA_W (clamp to 2^(DATA_W−1)−1 / −2^(DATA_W−1)).
- FSM:
  - IDLE: busy_o=0. tick_i=1 → LOAD (cycle 0 = accept cycle).
  - LOAD: all NUM_CH samples (captured in cycle 0) written at wp; ch=0 → MAC.
  - MAC: NUM_TAPS cycles issuing coeff_addr_o=k, k=0..NUM_TAPS−1, with matching sample read. Stage 1: ROM/sample fetch. Stage 2: registered product. Stage 3: accumulate. Accumulator cleared on k=0 issue.
  - DRAIN: 2 cycles to flush pipeline.
  - STORE: 1 cycle, saturated result into shadow register for ch. ch<NUM_CH−1 → ch+1, MAC; else DONE.
  - DONE: result_o ← shadow (all channels atomically); valid_o=1; wp ← (wp+1) mod NUM_TAPS; → IDLE.
- Latency: valid_o in cycle NUM_CH*(NUM_TAPS+3)+2 after accept (266 at defaults). result_o stable between valid pulses.
- busy_o=1 in every state except IDLE.
- tick_i while busy_o=1 (including DONE): dropped; overrun_o pulses the following cycle; in-progress computation unaffected.
- coeff_addr_o holds 0 when not in MAC.
- sample_i is only sampled in the accept cycle.

Test Plan:
- Impulse: bench OUT_SHIFT=0, ROM coeff[k]=k+1, NUM_CH=6, NUM_TAPS=41. Ch0 gets 1 then zeros over 41 ticks → ch0 outputs 1,2,…,41, then 0; other channels 0.
- DC: all channels 100 for 41+ ticks, coeff[k]=k+1 → steady result 100·861=86100 from 41st valid onward. Earlier outputs ramp per partial sums.
- Latency/busy: single tick at defaults → valid_o exactly 266 cycles after accept; busy_o high cycles 1–266 inclusive; coeff_addr_o sweeps 0..40 six times.
- Overrun: second tick at accept+100 and at the DONE cycle → overrun_o pulses at +101 and DONE+1; one valid only; wp advanced once.
- Saturation: OUT_SHIFT=0, sample 2^31−1, coeff all 2^31−1 → result 2^31−1. Sample −2^31 → −2^31.
- Reset mid-op: reset_ni low at accept+50 → all outputs 0 immediately, no valid_o. Next impulse reproduces the impulse-test sequence from a cleared delay line.
